// File: rtl/bp_be_dcache_pkg.sv
// Shared types and width helpers for the dcache trace issuer slice.
package bp_be_dcache_pkg;

  typedef enum logic [1:0] {
    BP_CFG_FLOWVAR,
    BP_CFG_TINY
  } bp_params_e;

  localparam int dcache_opcode_width_gp = 5;

  function automatic int bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      BP_CFG_TINY: return 32;
      default:     return 40;
    endcase
  endfunction

  function automatic int bp_page_offset_width(input bp_params_e cfg);
    case (cfg)
      BP_CFG_TINY: return 12;
      default:     return 12;
    endcase
  endfunction

  function automatic int bp_dword_width(input bp_params_e cfg);
    case (cfg)
      BP_CFG_TINY: return 32;
      default:     return 64;
    endcase
  endfunction

  // Packet layout is {opcode, page_offset, data}.
  function automatic int bp_be_dcache_pkt_width(input int page_offset_width, input int dword_width);
    return dcache_opcode_width_gp + page_offset_width + dword_width;
  endfunction

  localparam int ptag_width_lp       = bp_paddr_width(BP_CFG_FLOWVAR) - bp_page_offset_width(BP_CFG_FLOWVAR);
  localparam int dcache_pkt_width_lp = bp_be_dcache_pkt_width(bp_page_offset_width(BP_CFG_FLOWVAR),
                                                              bp_dword_width(BP_CFG_FLOWVAR));
  localparam int payload_width_lp    = 1 + ptag_width_lp + dcache_pkt_width_lp;

  typedef enum logic [1:0] {
    e_ready,
    e_tl,
    e_tv,
    e_miss
  } bp_be_dcache_issuer_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that saturates at max_val_p.
module bsg_counter_clear_up #(
  parameter int max_val_p  = 2**16-1,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p+1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_o <= init_lp;
    end else if (up_i && (count_o != max_lp)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous clear to zero.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o <= '0;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/bp_be_dcache_trace_issuer.sv
// Replays trace entries into the dcache one at a time, reissuing on a miss.
//
// state   | meaning
// e_ready | waiting for a trace entry; packet driven straight from the trace
// e_tl    | packet accepted, tag/uncached presented from the hold register
// e_tv    | waiting for the dcache to respond or report a miss
// e_miss  | reissuing the held packet once the dcache is ready
module bp_be_dcache_trace_issuer
  import bp_be_dcache_pkg::bp_params_e, bp_be_dcache_pkg::BP_CFG_FLOWVAR,
         bp_be_dcache_pkg::bp_paddr_width, bp_be_dcache_pkg::bp_page_offset_width,
         bp_be_dcache_pkg::bp_dword_width, bp_be_dcache_pkg::bp_be_dcache_pkt_width;
#(
  parameter bp_params_e bp_params_p = BP_CFG_FLOWVAR,
  parameter int timeout_p = 1024,
  localparam int paddr_width_p       = bp_paddr_width(bp_params_p),
  localparam int page_offset_width_p = bp_page_offset_width(bp_params_p),
  localparam int dword_width_p       = bp_dword_width(bp_params_p),
  localparam int ptag_width_lp       = paddr_width_p - page_offset_width_p,
  localparam int dcache_pkt_width_lp = bp_be_dcache_pkt_width(page_offset_width_p, dword_width_p),
  localparam int payload_width_lp    = 1 + ptag_width_lp + dcache_pkt_width_lp
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           trace_v_i,
  input  logic [payload_width_lp-1:0]    trace_data_i,
  output logic                           trace_yumi_o,
  output logic [dcache_pkt_width_lp-1:0] dcache_pkt_o,
  output logic                           dcache_v_o,
  input  logic                           dcache_ready_i,
  output logic [ptag_width_lp-1:0]       ptag_o,
  output logic                           uncached_o,
  input  logic                           dcache_resp_v_i,
  input  logic                           dcache_miss_i,
  input  logic                           resp_ready_i,
  output logic [15:0]                    issued_o,
  output logic [15:0]                    replays_o,
  output logic                           error_o
);

  import bp_be_dcache_pkg::bp_be_dcache_issuer_state_e;
  import bp_be_dcache_pkg::e_ready, bp_be_dcache_pkg::e_tl,
         bp_be_dcache_pkg::e_tv, bp_be_dcache_pkg::e_miss;

  localparam int wait_width_lp = $clog2(timeout_p+1);
  localparam logic [wait_width_lp-1:0] timeout_lp = wait_width_lp'(timeout_p);

  bp_be_dcache_issuer_state_e state_r;
  logic [payload_width_lp-1:0] hold_r;
  logic [wait_width_lp-1:0]    wait_cnt;
  logic issue, resp_done, miss_replay, state_change, waiting, timeout_hit, error_r;

  always_comb begin
    dcache_v_o = 1'b0;
    case (state_r)
      e_ready: dcache_v_o = trace_v_i & resp_ready_i;
      e_miss:  dcache_v_o = dcache_ready_i;
      default: dcache_v_o = 1'b0;
    endcase
    if (reset_i) dcache_v_o = 1'b0;
  end

  assign issue        = dcache_v_o & dcache_ready_i;
  assign trace_yumi_o = issue & (state_r == e_ready);
  // A response in the same cycle as a miss means the data arrived; ignore the miss.
  assign resp_done    = (state_r == e_tv) & dcache_resp_v_i;
  assign miss_replay  = (state_r == e_tv) & dcache_miss_i & ~dcache_resp_v_i;
  assign state_change = issue | (state_r == e_tl) | resp_done | miss_replay;
  assign waiting      = (state_r == e_tv) | (state_r == e_miss);

  assign dcache_pkt_o = (state_r == e_ready) ? trace_data_i[dcache_pkt_width_lp-1:0]
                                             : hold_r[dcache_pkt_width_lp-1:0];
  assign ptag_o       = hold_r[dcache_pkt_width_lp +: ptag_width_lp];
  assign uncached_o   = hold_r[payload_width_lp-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        e_ready: if (issue) state_r <= e_tl;
        e_tl:    state_r <= e_tv;
        e_tv: begin
          if (resp_done)        state_r <= e_ready;
          else if (miss_replay) state_r <= e_miss;
        end
        e_miss:  if (issue) state_r <= e_tl;
        default: state_r <= e_ready;
      endcase
      if (timeout_hit) error_r <= 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == timeout_lp);
  assign error_o     = ~reset_i & (error_r | timeout_hit);

  bsg_dff_reset_en #(.width_p(payload_width_lp)) hold_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (trace_yumi_o),
    .data_i  (trace_data_i),
    .data_o  (hold_r)
  );

  bsg_counter_clear_up #(.max_val_p(2**16-1)) issued_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .up_i    (resp_done),
    .count_o (issued_o)
  );

  bsg_counter_clear_up #(.max_val_p(2**16-1)) replays_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .up_i    (miss_replay),
    .count_o (replays_o)
  );

  // Saturates at timeout_p so a stuck wait never wraps back below the threshold.
  bsg_counter_clear_up #(.max_val_p(timeout_p)) wait_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_change),
    .up_i    (waiting),
    .count_o (wait_cnt)
  );

endmodule

// File: tb/tb_bp_be_dcache_trace_issuer.sv
// Directed bench for the dcache trace issuer: hit, miss/replay, backpressure, watchdog, reset.
module tb_bp_be_dcache_trace_issuer;
  import bp_be_dcache_pkg::*;

  localparam int timeout_lp = 40;

  logic clk_i = 1'b0;
  logic reset_i, trace_v_i, trace_yumi_o, dcache_v_o, dcache_ready_i;
  logic uncached_o, dcache_resp_v_i, dcache_miss_i, resp_ready_i, error_o;
  logic [payload_width_lp-1:0]    trace_data_i;
  logic [dcache_pkt_width_lp-1:0] dcache_pkt_o;
  logic [ptag_width_lp-1:0]       ptag_o;
  logic [15:0] issued_o, replays_o;

  int n_checks = 0;
  int n_pass = 0;
  int yumi_cnt = 0;
  int issue_cnt = 0;
  int yumi0, iss0, viol;

  logic [dcache_pkt_width_lp-1:0] pkt_a, pkt_b, pkt_c;

  always #5 clk_i = ~clk_i;

  bp_be_dcache_trace_issuer #(.timeout_p(timeout_lp)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .trace_v_i       (trace_v_i),
    .trace_data_i    (trace_data_i),
    .trace_yumi_o    (trace_yumi_o),
    .dcache_pkt_o    (dcache_pkt_o),
    .dcache_v_o      (dcache_v_o),
    .dcache_ready_i  (dcache_ready_i),
    .ptag_o          (ptag_o),
    .uncached_o      (uncached_o),
    .dcache_resp_v_i (dcache_resp_v_i),
    .dcache_miss_i   (dcache_miss_i),
    .resp_ready_i    (resp_ready_i),
    .issued_o        (issued_o),
    .replays_o       (replays_o),
    .error_o         (error_o)
  );

  always @(posedge clk_i) begin
    if (!reset_i) begin
      yumi_cnt  <= yumi_cnt + int'(trace_yumi_o);
      issue_cnt <= issue_cnt + int'(dcache_v_o & dcache_ready_i);
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [payload_width_lp-1:0] mk(input logic unc,
                                                      input logic [ptag_width_lp-1:0] ptag,
                                                      input logic [dcache_pkt_width_lp-1:0] pkt);
    return {unc, ptag, pkt};
  endfunction

  initial begin
    pkt_a = {5'h03, 12'h040, 64'hDEAD_BEEF_0000_0001};
    pkt_b = {5'h11, 12'hABC, 64'h0123_4567_89AB_CDEF};
    pkt_c = {5'h1F, 12'h555, 64'hFFFF_0000_AAAA_5555};

    reset_i = 1'b1; trace_v_i = 1'b1; trace_data_i = mk(1'b0, 28'h10, pkt_a);
    dcache_ready_i = 1'b1; resp_ready_i = 1'b1; dcache_resp_v_i = 1'b0; dcache_miss_i = 1'b0;
    repeat (3) tick();
    check_val("rst_v", dcache_v_o, 0);
    check_val("rst_yumi", trace_yumi_o, 0);
    trace_v_i = 1'b0; reset_i = 1'b0;
    tick();
    check_val("init_issued", issued_o, 0);
    check_val("init_replays", replays_o, 0);
    check_val("init_error", error_o, 0);
    check_val("init_ptag", ptag_o, 0);
    check_val("init_unc", uncached_o, 0);

    // load hit
    yumi0 = yumi_cnt; iss0 = issue_cnt;
    trace_v_i = 1'b1; trace_data_i = mk(1'b0, 28'h10, pkt_a);
    #1;
    check_val("hit_v", dcache_v_o, 1);
    check_val("hit_yumi", trace_yumi_o, 1);
    check_val("hit_pkt", dcache_pkt_o, pkt_a);
    tick();
    trace_v_i = 1'b0; trace_data_i = '0;
    #1;
    check_val("hit_tl_ptag", ptag_o, 28'h10);
    check_val("hit_tl_unc", uncached_o, 0);
    check_val("hit_tl_v", dcache_v_o, 0);
    tick();
    dcache_resp_v_i = 1'b1; tick(); dcache_resp_v_i = 1'b0;
    check_val("hit_issued", issued_o, 1);
    check_val("hit_replays", replays_o, 0);
    check_val("hit_yumi_count", yumi_cnt - yumi0, 1);

    // load miss with a 20-cycle stall before the replay
    yumi0 = yumi_cnt; iss0 = issue_cnt;
    trace_v_i = 1'b1; trace_data_i = mk(1'b1, 28'h2AB, pkt_b);
    tick();
    trace_v_i = 1'b0; trace_data_i = mk(1'b0, 28'h3FF, pkt_c);
    tick();
    dcache_miss_i = 1'b1; dcache_ready_i = 1'b0;
    tick();
    dcache_miss_i = 1'b0;
    #1;
    check_val("miss_replays", replays_o, 1);
    check_val("miss_issued", issued_o, 1);
    viol = 0;
    repeat (20) begin
      if (dcache_v_o) viol++;
      tick();
    end
    check_val("miss_stall_v", viol, 0);
    dcache_ready_i = 1'b1;
    #1;
    check_val("replay_v", dcache_v_o, 1);
    check_val("replay_pkt", dcache_pkt_o, pkt_b);
    check_val("replay_yumi", trace_yumi_o, 0);
    tick();
    check_val("replay_ptag", ptag_o, 28'h2AB);
    check_val("replay_unc", uncached_o, 1);
    check_val("replay_tl_v", dcache_v_o, 0);
    tick();
    dcache_resp_v_i = 1'b1; tick(); dcache_resp_v_i = 1'b0;
    check_val("miss_done_issued", issued_o, 2);
    check_val("miss_done_replays", replays_o, 1);
    check_val("miss_issue_count", issue_cnt - iss0, 2);
    check_val("miss_yumi_count", yumi_cnt - yumi0, 1);
    check_val("miss_error", error_o, 0);

    // backpressure from the response FIFO
    yumi0 = yumi_cnt; iss0 = issue_cnt; viol = 0;
    trace_v_i = 1'b1; resp_ready_i = 1'b0; trace_data_i = mk(1'b0, 28'h55, pkt_c);
    repeat (10) begin
      #1;
      if (dcache_v_o || trace_yumi_o) viol++;
      tick();
    end
    check_val("bp_outputs", viol, 0);
    check_val("bp_yumi_count", yumi_cnt - yumi0, 0);
    check_val("bp_issue_count", issue_cnt - iss0, 0);
    resp_ready_i = 1'b1;
    #1;
    check_val("bp_resume_v", dcache_v_o, 1);

    // response and miss on the same cycle
    tick();
    trace_v_i = 1'b0;
    tick();
    dcache_resp_v_i = 1'b1; dcache_miss_i = 1'b1;
    tick();
    dcache_resp_v_i = 1'b0; dcache_miss_i = 1'b0;
    #1;
    check_val("both_issued", issued_o, 3);
    check_val("both_replays", replays_o, 1);
    check_val("both_not_miss_v", dcache_v_o, 0);

    // watchdog
    trace_v_i = 1'b1; trace_data_i = mk(1'b0, 28'h77, pkt_a);
    tick();
    trace_v_i = 1'b0;
    tick();
    repeat (timeout_lp-1) tick();
    check_val("wd_before", error_o, 0);
    tick();
    check_val("wd_rise", error_o, 1);
    repeat (5) tick();
    check_val("wd_sticky", error_o, 1);
    dcache_resp_v_i = 1'b1; tick(); dcache_resp_v_i = 1'b0;
    check_val("wd_issued", issued_o, 4);
    check_val("wd_sticky_ready", error_o, 1);

    // reset while waiting for a replay
    trace_v_i = 1'b1; trace_data_i = mk(1'b1, 28'h99, pkt_b);
    tick();
    trace_v_i = 1'b0;
    tick();
    dcache_miss_i = 1'b1; dcache_ready_i = 1'b0;
    tick();
    dcache_miss_i = 1'b0;
    check_val("rm_replays", replays_o, 2);
    iss0 = issue_cnt;
    reset_i = 1'b1; dcache_ready_i = 1'b1;
    #1;
    check_val("rm_rst_v", dcache_v_o, 0);
    tick();
    reset_i = 1'b0;
    #1;
    check_val("rm_no_replay_v", dcache_v_o, 0);
    check_val("rm_issued", issued_o, 0);
    check_val("rm_replays_clr", replays_o, 0);
    check_val("rm_error", error_o, 0);
    check_val("rm_ptag", ptag_o, 0);
    check_val("rm_unc", uncached_o, 0);
    repeat (3) tick();
    check_val("rm_issue_count", issue_cnt - iss0, 0);

    // normal operation after reset
    trace_v_i = 1'b1; trace_data_i = mk(1'b1, 28'h10, pkt_c);
    tick();
    trace_v_i = 1'b0;
    #1;
    check_val("post_ptag", ptag_o, 28'h10);
    check_val("post_unc", uncached_o, 1);
    tick();
    dcache_resp_v_i = 1'b1; tick(); dcache_resp_v_i = 1'b0;
    check_val("post_issued", issued_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_trace_issuer.md
BP_BE_DCACHE_TRACE_ISSUER -- requirements
Module: bp_be_dcache_trace_issuer

Interface
REQ-001 Parameter bp_params_p, default BP_CFG_FLOWVAR: processor configuration; supplies paddr_width_p, page_offset_width_p and dword_width_p.
REQ-002 Parameter timeout_p, default 1024: maximum cycles allowed in any wait state before error_o is raised.
REQ-003 Derived width ptag_width_lp = paddr_width_p - page_offset_width_p.
REQ-004 Derived width dcache_pkt_width_lp = bp_be_dcache_pkt_width(page_offset_width_p, dword_width_p).
REQ-005 Derived width payload_width_lp = 1 + ptag_width_lp + dcache_pkt_width_lp.
REQ-006 clk_i  in  1  sole clock; one clock, all state on posedge clk_i.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 trace_v_i  in  1  trace entry valid.
REQ-009 trace_data_i  in  payload_width_lp  {uncached, ptag, dcache_pkt}, with dcache_pkt in the LSBs.
REQ-010 trace_yumi_o  out  1  entry consumed.
REQ-011 dcache_pkt_o  out  dcache_pkt_width_lp  packet to the dcache TL stage.
REQ-012 dcache_v_o  out  1  packet valid.
REQ-013 dcache_ready_i  in  1  dcache can accept a packet.
REQ-014 ptag_o  out  ptag_width_lp  physical tag, presented the cycle after issue.
REQ-015 uncached_o  out  1  uncached flag, presented the cycle after issue.
REQ-016 dcache_resp_v_i  in  1  dcache completed an operation (load data or store ack).
REQ-017 dcache_miss_i  in  1  dcache missed on the current operation.
REQ-018 resp_ready_i  in  1  downstream response FIFO has space.
REQ-019 issued_o  out  16  count of completed operations.
REQ-020 replays_o  out  16  count of miss replays.
REQ-021 error_o  out  1  sticky watchdog timeout flag.

Function
REQ-022 The FSM SHALL have exactly four states: e_ready, e_tl, e_tv, e_miss.
REQ-023 e_ready: dcache_v_o = trace_v_i & resp_ready_i; on dcache_v_o & dcache_ready_i the block SHALL assert trace_yumi_o, latch the payload into a hold register, and go to e_tl.
REQ-024 e_tl: ptag_o and uncached_o SHALL come from the hold register; dcache_v_o = 0; next state e_tv.
REQ-025 e_tv, dcache_resp_v_i = 1: increment issued_o and go to e_ready.
REQ-026 e_tv, dcache_miss_i = 1: increment replays_o and go to e_miss.
REQ-027 e_tv, dcache_resp_v_i and dcache_miss_i both 1: the response SHALL win (the miss is ignored).
REQ-028 e_tv, neither input set: hold in e_tv.
REQ-029 e_miss: dcache_v_o = dcache_ready_i, with dcache_pkt_o taken from the hold register; on issue go to e_tl; trace_yumi_o = 0.
REQ-030 dcache_pkt_o SHALL carry the hold-register packet in every state except e_ready, where it is driven combinationally from trace_data_i.
REQ-031 At most one operation SHALL be outstanding at any time.
REQ-032 A new trace entry SHALL be accepted only when resp_ready_i = 1.
REQ-033 Issue-to-ptag latency SHALL be exactly one cycle.
REQ-034 issued_o and replays_o SHALL saturate at 16'hFFFF (no wrap-around).
REQ-035 A wait counter SHALL clear on every state change and increment while in e_tv or e_miss.
REQ-036 When the wait counter reaches timeout_p, error_o SHALL set and stay set until reset; the FSM continues operating.
REQ-037 trace_yumi_o SHALL never assert when trace_v_i = 0.

Reset
REQ-038 While reset_i is high: state = e_ready; counters, hold register and error_o are cleared; dcache_v_o = 0; trace_yumi_o = 0.
REQ-039 Reset asserted in any state, including mid-miss, SHALL abandon the held operation without a replay.
REQ-040 Outputs ptag_o and uncached_o SHALL read 0 after reset until the first issue.

Structure
REQ-041 The state enum bp_be_dcache_issuer_state_e and payload_width_lp SHALL live in bp_be_dcache_pkg.
REQ-042 Saturating counters SHALL use one sub-module, bsg_counter_clear_up, instantiated with max_val_p = 2**16-1.
REQ-043 The hold register SHALL use bsg_dff_reset_en.

Verification
REQ-044 Load hit: trace entry ptag=0x10, resp on cycle 2 -> ptag_o=0x10 in e_tl, issued_o=1, exactly one trace_yumi_o.
REQ-045 Load miss: miss in e_tv, dcache_ready_i low 20 cycles then high -> exactly one reissue of the identical packet, replays_o=1, then issued_o=1.
REQ-046 Backpressure: resp_ready_i=0 with trace_v_i=1 for 10 cycles -> dcache_v_o=0 and trace_yumi_o=0 throughout.
REQ-047 Response and miss on the same cycle -> the response wins: issued_o increments, replays_o is unchanged.
REQ-048 Watchdog: no response for timeout_p cycles -> error_o rises on the cycle the count reaches timeout_p and stays high.
REQ-049 Reset in e_miss -> next cycle state = e_ready, counters 0, no replay issued.
